uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 155 +++++++++++++++
 tb/tb_uart_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, framed as 8N1, 8N2, 8E1 or 8O1.
// uart_txd and tx_busy are registered from the current state, so the line lags the FSM
// by one clock: the start bit appears on the edge after the accept edge.
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       uart_clk,
    input  logic       uart_rst,
    input  logic [7:0] uart_wr_data,
    input  logic       uart_wr_valid,
    output logic       uart_wr_ready,
    input  logic [1:0] uart_mode,
    output logic       uart_txd,
    output logic       tx_busy
);

    localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    // Wide enough to count a double-length stop bit.
    localparam int unsigned CNT_W      = $clog2(2 * BIT_CYCLES);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STOP2_LAST = CNT_W'(2 * BIT_CYCLES - 1);

    if (BIT_CYCLES < 2) begin : g_bad_baud
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic [1:0]       mode_q, mode_d;
    logic             txd_q, txd_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;

    logic             accept;
    logic             bit_done;
    logic [CNT_W-1:0] stop_last;

    assign accept    = uart_wr_valid && ready_q;
    assign bit_done  = (cnt_q == BIT_LAST);
    assign stop_last = (mode_q == 2'b01) ? STOP2_LAST : BIT_LAST;

    // State, counters, latched frame and registered outputs.
    always_ff @(posedge uart_clk or negedge uart_rst) begin
        if (!uart_rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            mode_q  <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic: the baud counter reloads at every bit boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mode_d  = mode_q;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                idx_d = '0;
                if (accept) begin
                    data_d  = uart_wr_data;
                    mode_d  = uart_mode;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == 3'd7) begin
                        state_d = mode_q[1] ? StParity : StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StParity: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (cnt_q == stop_last) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Output decode from the current state; registered one clock later onto the line.
    always_comb begin
        txd_d   = 1'b1;
        busy_d  = state_q inside {StStart, StData, StParity, StStop};
        ready_d = (state_d == StIdle);
        case (state_q)
            StStart:  txd_d = 1'b0;
            StData:   txd_d = data_q[idx_q];
            // Mode 10 even, 11 odd: mode bit 0 inverts the XOR.
            StParity: txd_d = (^data_q) ^ mode_q[0];
            default:  txd_d = 1'b1;
        endcase
    end

    assign uart_wr_ready = ready_q;
    assign uart_txd      = txd_q;
    assign tx_busy       = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line waveforms are built per frame from the
// frame-format rules (slot list expanded by the bit time) and compared cycle by cycle.
module tb_uart_tx;

    localparam int unsigned CLK_FREQ  = 1000000;
    localparam int unsigned BAUD_RATE = 57000;
    // 17.54 truncated to 17 clocks per bit.
    localparam int BIT = CLK_FREQ / BAUD_RATE;

    logic       uart_clk = 1'b0;
    logic       uart_rst = 1'b1;
    logic [7:0] uart_wr_data = 8'h00;
    logic       uart_wr_valid = 1'b0;
    logic [1:0] uart_mode = 2'b00;
    logic       uart_wr_ready;
    logic       uart_txd;
    logic       tx_busy;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE)
    ) dut (
        .uart_clk     (uart_clk),
        .uart_rst     (uart_rst),
        .uart_wr_data (uart_wr_data),
        .uart_wr_valid(uart_wr_valid),
        .uart_wr_ready(uart_wr_ready),
        .uart_mode    (uart_mode),
        .uart_txd     (uart_txd),
        .tx_busy      (tx_busy)
    );

    always #5 uart_clk = ~uart_clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required end before", $time);
        $fatal(1, "watchdog");
    end

    // Offers one byte, waits for the handshake, then checks the whole frame on the line.
    // Called at a negedge; returns at the negedge holding the last stop-bit sample.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] m, input bit hold,
                             input logic [7:0] next_d, input logic [1:0] next_m,
                             input bit expect_immediate, input string tag);
        bit   slots[$];
        int   waited = 0;
        int   samples;
        int   k = 0;
        logic got;
        logic bad_txd;
        logic bad_ctl;
        logic first_got;
        uart_wr_data  = d;
        uart_mode     = m;
        uart_wr_valid = 1'b1;
        while (uart_wr_ready !== 1'b1 && waited < 64) begin
            @(negedge uart_clk);
            waited++;
        end
        n_tests++;
        if (uart_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_handshake: ready=%b required 1 within 64 cycles", tag,
                     uart_wr_ready);
            uart_wr_valid = 1'b0;
            return;
        end
        if (expect_immediate) begin
            n_tests++;
            if (waited != 0) begin
                n_fail++;
                $display("FAIL %s_gap: waited %0d cycles for ready, required 0", tag, waited);
            end
        end
        @(posedge uart_clk);
        #1;
        uart_wr_data  = next_d;
        uart_mode     = next_m;
        uart_wr_valid = hold;
        @(negedge uart_clk);
        n_tests++;
        if (uart_wr_ready !== 1'b0 || uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_accept_cycle: ready=%b txd=%b busy=%b required 0 1 0", tag,
                     uart_wr_ready, uart_txd, tx_busy);
        end
        // Frame as a list of line levels, one per bit slot.
        slots.push_back(1'b0);
        for (int i = 0; i < 8; i++) slots.push_back(d[i]);
        if (m[1]) slots.push_back((($countones(d) % 2) == 1) ^ m[0]);
        slots.push_back(1'b1);
        if (m == 2'b01) slots.push_back(1'b1);
        samples = slots.size() * BIT;
        bad_ctl = 1'b0;
        for (int s = 0; s < slots.size(); s++) begin
            bad_txd   = 1'b0;
            first_got = 1'b0;
            for (int c = 0; c < BIT; c++) begin
                @(negedge uart_clk);
                k++;
                got = uart_txd;
                if (got !== slots[s] && !bad_txd) begin
                    bad_txd   = 1'b1;
                    first_got = got;
                end
                // Ready comes back during the final stop-bit clock.
                if (tx_busy !== 1'b1 || uart_wr_ready !== (k == samples)) bad_ctl = 1'b1;
            end
            n_tests++;
            if (bad_txd) begin
                n_fail++;
                $display("FAIL %s_slot%0d: txd=%b required %b", tag, s, first_got, slots[s]);
            end
        end
        n_tests++;
        if (bad_ctl) begin
            n_fail++;
            $display("FAIL %s_busy_ready: busy/ready deviated during %0d-cycle frame, required busy=1 ready=0",
                     tag, samples);
        end
    endtask

    task automatic test_reset();
        logic bad = 1'b0;
        uart_rst = 1'b1;
        #2 uart_rst = 1'b0;
        #1;
        n_tests++;
        if (uart_txd !== 1'b1 || uart_wr_ready !== 1'b0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: txd=%b ready=%b busy=%b required 1 0 0", uart_txd,
                     uart_wr_ready, tx_busy);
        end
        repeat (3) @(negedge uart_clk);
        uart_rst = 1'b1;
        #1;
        n_tests++;
        if (uart_wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready_early: ready=%b required 0", uart_wr_ready);
        end
        @(negedge uart_clk);
        n_tests++;
        if (uart_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: ready=%b required 1", uart_wr_ready);
        end
        repeat (10) begin
            @(negedge uart_clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || uart_wr_ready !== 1'b1) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL reset_idle_line: line left idle, required txd=1 busy=0 ready=1");
        end
    endtask

    task automatic test_idle_after(input string tag);
        @(negedge uart_clk);
        n_tests++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || uart_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle: txd=%b busy=%b ready=%b required 1 0 1", tag, uart_txd,
                     tx_busy, uart_wr_ready);
        end
    endtask

    task automatic test_8n1();
        run_frame(8'h55, 2'b00, 1'b0, 8'hAA, 2'b01, 1'b0, "8n1_55");
        test_idle_after("8n1_55");
    endtask

    task automatic test_parity();
        run_frame(8'hA3, 2'b10, 1'b0, 8'h5C, 2'b11, 1'b0, "8e1_a3");
        test_idle_after("8e1_a3");
        run_frame(8'hA3, 2'b11, 1'b0, 8'h00, 2'b00, 1'b0, "8o1_a3");
        test_idle_after("8o1_a3");
    endtask

    task automatic test_two_stop();
        run_frame(8'hFF, 2'b01, 1'b0, 8'h00, 2'b00, 1'b0, "8n2_ff");
        test_idle_after("8n2_ff");
    endtask

    task automatic test_back_to_back();
        logic bad = 1'b0;
        run_frame(8'h00, 2'b00, 1'b1, 8'hFF, 2'b00, 1'b0, "b2b_00");
        run_frame(8'hFF, 2'b00, 1'b0, 8'h3C, 2'b10, 1'b1, "b2b_ff");
        repeat (3 * BIT) begin
            @(negedge uart_clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL b2b_third_frame: line activity after two frames, required idle");
        end
    endtask

    task automatic test_reset_mid_frame();
        logic bad = 1'b0;
        uart_wr_data  = 8'h0F;
        uart_mode     = 2'b00;
        uart_wr_valid = 1'b1;
        while (uart_wr_ready !== 1'b1) @(negedge uart_clk);
        @(posedge uart_clk);
        #1 uart_wr_valid = 1'b0;
        // Accept-cycle sample, start bit, data bits 0..2, then half of bit 3.
        repeat (1 + 4 * BIT + BIT / 2) @(negedge uart_clk);
        n_tests++;
        if (tx_busy !== 1'b1 || uart_txd !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_bit3: busy=%b txd=%b required 1 1", tx_busy, uart_txd);
        end
        uart_rst = 1'b0;
        #1;
        n_tests++;
        if (uart_txd !== 1'b1 || tx_busy !== 1'b0 || uart_wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: txd=%b busy=%b ready=%b required 1 0 0", uart_txd,
                     tx_busy, uart_wr_ready);
        end
        @(negedge uart_clk);
        uart_rst = 1'b1;
        @(negedge uart_clk);
        n_tests++;
        if (uart_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_ready: ready=%b required 1", uart_wr_ready);
        end
        repeat (4 * BIT) begin
            @(negedge uart_clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_mid_resend: aborted byte reappeared, required idle line");
        end
        run_frame(8'h81, 2'b00, 1'b0, 8'h0F, 2'b00, 1'b0, "rst_mid_81");
        test_idle_after("rst_mid_81");
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [1:0] m;
        for (int n = 0; n < 8; n++) begin
            d = 8'($urandom);
            m = 2'($urandom_range(0, 3));
            run_frame(d, m, 1'b0, 8'($urandom), 2'($urandom), 1'b0,
                      $sformatf("rand%0d_%02h_m%0d", n, d, m));
            repeat ($urandom_range(0, 3)) @(negedge uart_clk);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
